// File: rtl/gdb_packet_tx.sv
// GDB remote serial protocol transmitter: buffers a reply payload and frames it as
// $<payload>#<cs_hi><cs_lo>. It then waits for the host's '+'/'-' ack and retransmits on NAK or timeout.
module gdb_packet_tx #(
    parameter int          DEPTH       = 64,
    parameter int          AW          = 6,
    parameter int          GAP         = 2,
    parameter logic [23:0] ACK_TIMEOUT = 24'hFFFFFF,
    parameter int          MAX_RETRY   = 3
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       ld_we_i,
    input  logic [7:0] ld_dat_i,
    input  logic       start_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic [7:0] tx_byte_o,
    output logic       tx_send_o,
    input  logic       tx_ready_i,
    input  logic [7:0] rx_byte_i,
    input  logic       rx_available_i,
    output logic       rx_read_o
);

    localparam int GW = (GAP < 2) ? 1 : $clog2(GAP);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [AW:0] LEN_FULL = (AW + 1)'(DEPTH);
    localparam logic [23:0] TO_LAST = ACK_TIMEOUT - 24'd1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_DOLLAR,
        S_PAYLOAD,
        S_HASH,
        S_CS_HI,
        S_CS_LO,
        S_GAP,
        S_WAIT_ACK,
        S_ACK_READ
    } state_t;

    state_t        r_state;
    state_t        r_after;
    logic [GW-1:0] r_gap;
    logic [AW:0]   r_len;
    logic [AW:0]   r_idx;
    logic [7:0]    r_csum;
    logic [23:0]   r_to_cnt;
    logic [RW-1:0] r_retry;
    logic [7:0]    r_buf [DEPTH];

    logic       w_ld;
    logic [7:0] w_rd;
    logic       w_ack;
    logic       w_nak;

    function automatic logic [7:0] hex_lc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    assign w_ld  = (r_state == S_IDLE) && ld_we_i && (r_len != LEN_FULL);
    assign w_rd  = r_buf[r_idx[AW-1:0]];
    assign w_ack = (r_state == S_ACK_READ) && (rx_byte_i == 8'h2B);
    // A '-' and a silent host are handled identically.
    assign w_nak = ((r_state == S_ACK_READ) && (rx_byte_i == 8'h2D)) ||
                   ((r_state == S_WAIT_ACK) && !rx_available_i && (r_to_cnt == TO_LAST));

    always_ff @(posedge clk_i) begin
        if (w_ld) r_buf[r_len[AW-1:0]] <= ld_dat_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= S_IDLE;
            r_after   <= S_IDLE;
            r_gap     <= '0;
            r_len     <= '0;
            r_idx     <= '0;
            r_csum    <= '0;
            r_to_cnt  <= '0;
            r_retry   <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
            tx_byte_o <= 8'h00;
            tx_send_o <= 1'b0;
            rx_read_o <= 1'b0;
        end else begin
            tx_send_o <= 1'b0;
            rx_read_o <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
            if (w_ld) r_len <= r_len + 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        busy_o  <= 1'b1;
                        r_state <= S_DOLLAR;
                    end
                end
                S_DOLLAR: begin
                    if (tx_ready_i) begin
                        tx_byte_o <= 8'h24;
                        tx_send_o <= 1'b1;
                        r_csum    <= '0;
                        r_idx     <= '0;
                        r_gap     <= '0;
                        r_after   <= S_PAYLOAD;
                        r_state   <= S_GAP;
                    end
                end
                S_PAYLOAD: begin
                    if (r_idx == r_len) begin
                        r_state <= S_HASH;
                    end else if (tx_ready_i) begin
                        tx_byte_o <= w_rd;
                        tx_send_o <= 1'b1;
                        r_csum    <= r_csum + w_rd;
                        r_idx     <= r_idx + 1'b1;
                        r_gap     <= '0;
                        r_after   <= S_PAYLOAD;
                        r_state   <= S_GAP;
                    end
                end
                S_HASH: begin
                    if (tx_ready_i) begin
                        tx_byte_o <= 8'h23;
                        tx_send_o <= 1'b1;
                        r_gap     <= '0;
                        r_after   <= S_CS_HI;
                        r_state   <= S_GAP;
                    end
                end
                S_CS_HI: begin
                    if (tx_ready_i) begin
                        tx_byte_o <= hex_lc(r_csum[7:4]);
                        tx_send_o <= 1'b1;
                        r_gap     <= '0;
                        r_after   <= S_CS_LO;
                        r_state   <= S_GAP;
                    end
                end
                S_CS_LO: begin
                    if (tx_ready_i) begin
                        tx_byte_o <= hex_lc(r_csum[3:0]);
                        tx_send_o <= 1'b1;
                        r_to_cnt  <= '0;
                        r_gap     <= '0;
                        r_after   <= S_WAIT_ACK;
                        r_state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gap == GAP_LAST) r_state <= r_after;
                    else                   r_gap   <= r_gap + 1'b1;
                end
                S_WAIT_ACK: begin
                    r_to_cnt <= r_to_cnt + 24'd1;
                    if (rx_available_i) begin
                        rx_read_o <= 1'b1;
                        r_state   <= S_ACK_READ;
                    end
                end
                S_ACK_READ: begin
                    // Noise bytes drop back to waiting; the timeout keeps running.
                    r_state <= S_WAIT_ACK;
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_ack) begin
                done_o  <= 1'b1;
                busy_o  <= 1'b0;
                r_len   <= '0;
                r_retry <= '0;
                r_state <= S_IDLE;
            end else if (w_nak) begin
                if (r_retry == RETRY_MAX) begin
                    err_o   <= 1'b1;
                    busy_o  <= 1'b0;
                    r_len   <= '0;
                    r_retry <= '0;
                    r_state <= S_IDLE;
                end else begin
                    r_retry <= r_retry + 1'b1;
                    r_state <= S_DOLLAR;
                end
            end
        end
    end

endmodule

// File: tb/tb_gdb_packet_tx.sv
// Directed bench for gdb_packet_tx: a UART stub captures transmitted bytes and serves queued ack bytes.
module tb_gdb_packet_tx;

    localparam int GAP = 2;
    localparam int TO  = 16;

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b0;
    logic       ld_we_i = 1'b0;
    logic [7:0] ld_dat_i = 8'h00;
    logic       start_i = 1'b0;
    logic       busy_o, done_o, err_o, tx_send_o, rx_read_o;
    logic [7:0] tx_byte_o;
    logic       tx_ready_i = 1'b1;
    logic [7:0] rx_byte_i = 8'h00;
    logic       rx_available_i = 1'b0;

    gdb_packet_tx #(
        .DEPTH(64), .AW(6), .GAP(GAP), .ACK_TIMEOUT(24'(TO)), .MAX_RETRY(3)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .ld_we_i(ld_we_i), .ld_dat_i(ld_dat_i), .start_i(start_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .tx_byte_o(tx_byte_o), .tx_send_o(tx_send_o), .tx_ready_i(tx_ready_i),
        .rx_byte_i(rx_byte_i), .rx_available_i(rx_available_i), .rx_read_o(rx_read_o)
    );

    always #5 clk_i = ~clk_i;

    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    int         n_done = 0;
    int         n_err = 0;
    logic [7:0] txq [$];
    int         txt [$];
    logic [7:0] rxq [$];
    logic [7:0] expq [$];

    always @(posedge clk_i) cyc <= cyc + 1;

    // UART stub: capture strobed bytes, pop the rx FIFO on rx_read_o
    always @(negedge clk_i) begin
        if (rst_n_i) begin
            if (tx_send_o) begin
                txq.push_back(tx_byte_o);
                txt.push_back(cyc);
            end
            if (done_o) n_done++;
            if (err_o)  n_err++;
            if (rx_read_o && rxq.size() > 0) rx_byte_i = rxq.pop_front();
        end
        rx_available_i = (rxq.size() != 0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        txq.delete();
        txt.delete();
        n_done = 0;
        n_err  = 0;
    endtask

    task automatic load(input logic [7:0] b);
        @(negedge clk_i);
        ld_we_i = 1'b1; ld_dat_i = b;
        @(negedge clk_i);
        ld_we_i = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy_o && n < 3000) begin
            @(posedge clk_i);
            n++;
        end
        if (busy_o) chk({tag, "_idle_timeout"}, 32'(busy_o), 32'd0);
        repeat (4) @(negedge clk_i);
    endtask

    task automatic wait_bytes(input string tag, input int cnt);
        int n;
        n = 0;
        while (txq.size() < cnt && n < 3000) begin
            @(posedge clk_i);
            n++;
        end
        if (txq.size() < cnt) chk({tag, "_bytes_timeout"}, 32'(txq.size()), 32'(cnt));
    endtask

    task automatic chk_frames(input string tag, input int reps);
        int n;
        n = expq.size();
        chk({tag, "_len"}, 32'(txq.size()), 32'(n * reps));
        for (int r = 0; r < reps; r++)
            for (int i = 0; i < n; i++)
                if (r * n + i < txq.size())
                    chk($sformatf("%s_b%0d_%0d", tag, r, i), 32'(txq[r * n + i]), 32'(expq[i]));
    endtask

    initial begin
        int sz;
        repeat (3) @(negedge clk_i);
        #1;
        chk("rst_outs", {26'd0, busy_o, done_o, err_o, tx_send_o, rx_read_o, 1'b0}, 32'd0);
        chk("rst_byte", 32'(tx_byte_o), 32'h00);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (2) @(negedge clk_i);

        // "OK" with '+' already queued: ack must wait until the frame is out
        clear_obs();
        rxq.push_back(8'h2B);
        load(8'h4F); load(8'h4B);
        pulse_start();
        chk("ok_busy", 32'(busy_o), 32'd1);
        wait_idle("ok");
        expq = '{8'h24, 8'h4F, 8'h4B, 8'h23, 8'h39, 8'h61};
        chk_frames("ok", 1);
        chk("ok_done", 32'(n_done), 32'd1);
        chk("ok_err", 32'(n_err), 32'd0);
        chk("ok_busy_low", 32'(busy_o), 32'd0);

        // Empty payload (also proves len cleared after the ack)
        clear_obs();
        rxq.push_back(8'h2B);
        pulse_start();
        wait_idle("empty");
        expq = '{8'h24, 8'h23, 8'h30, 8'h30};
        chk_frames("empty", 1);
        chk("empty_done", 32'(n_done), 32'd1);

        // "S05": NAK then ACK -> identical frame twice
        clear_obs();
        rxq.push_back(8'h2D); rxq.push_back(8'h2B);
        load(8'h53); load(8'h30); load(8'h35);
        pulse_start();
        wait_idle("s05");
        expq = '{8'h24, 8'h53, 8'h30, 8'h35, 8'h23, 8'h62, 8'h38};
        chk_frames("s05", 2);
        chk("s05_done", 32'(n_done), 32'd1);
        chk("s05_err", 32'(n_err), 32'd0);

        // Always NAK: first send + 3 retries, then err
        clear_obs();
        repeat (4) rxq.push_back(8'h2D);
        load(8'h4F); load(8'h4B);
        pulse_start();
        wait_idle("retry");
        expq = '{8'h24, 8'h4F, 8'h4B, 8'h23, 8'h39, 8'h61};
        chk_frames("retry", 4);
        chk("retry_err", 32'(n_err), 32'd1);
        chk("retry_done", 32'(n_done), 32'd0);
        chk("retry_busy", 32'(busy_o), 32'd0);

        // Noise byte discarded; load and start in the same cycle
        clear_obs();
        rxq.push_back(8'h03); rxq.push_back(8'h2B);
        @(negedge clk_i);
        ld_we_i = 1'b1; ld_dat_i = 8'h67; start_i = 1'b1;
        @(negedge clk_i);
        ld_we_i = 1'b0; start_i = 1'b0;
        wait_idle("noise");
        expq = '{8'h24, 8'h67, 8'h23, 8'h36, 8'h37};
        chk_frames("noise", 1);
        chk("noise_done", 32'(n_done), 32'd1);
        chk("noise_rxq", 32'(rxq.size()), 32'd0);

        // Silent host: frame resent after TO cycles in WAIT_ACK
        clear_obs();
        load(8'h4F); load(8'h4B);
        pulse_start();
        wait_bytes("tmo", 12);
        rxq.push_back(8'h2B);
        wait_idle("tmo");
        expq = '{8'h24, 8'h4F, 8'h4B, 8'h23, 8'h39, 8'h61};
        chk_frames("tmo", 2);
        chk("tmo_done", 32'(n_done), 32'd1);
        // cs_lo strobe -> GAP gap cycles -> TO wait cycles -> SEND_DOLLAR -> '$' strobe
        if (txt.size() >= 7) chk("tmo_delay", 32'(txt[6] - txt[5]), 32'(GAP + TO + 1));

        // tx_ready_i low for 10 cycles after 'B'
        clear_obs();
        rxq.push_back(8'h2B);
        load(8'h41); load(8'h42); load(8'h43); load(8'h44);
        pulse_start();
        wait_bytes("stall", 3);
        @(negedge clk_i);
        tx_ready_i = 1'b0;
        sz = txq.size();
        repeat (10) @(negedge clk_i);
        @(posedge clk_i);
        chk("stall_quiet", 32'(txq.size()), 32'(sz));
        @(negedge clk_i);
        tx_ready_i = 1'b1;
        wait_idle("stall");
        expq = '{8'h24, 8'h41, 8'h42, 8'h43, 8'h44, 8'h23, 8'h30, 8'h61};
        chk_frames("stall", 1);
        chk("stall_done", 32'(n_done), 32'd1);

        // Reset mid-payload
        clear_obs();
        for (int i = 0; i < 8; i++) load(8'h30 + 8'(i));
        pulse_start();
        wait_bytes("mrst", 2);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("mrst_outs", {26'd0, busy_o, done_o, err_o, tx_send_o, rx_read_o, 1'b0}, 32'd0);
        chk("mrst_byte", 32'(tx_byte_o), 32'h00);
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
        clear_obs();
        repeat (10) @(negedge clk_i);
        chk("mrst_quiet", 32'(txq.size()), 32'd0);
        chk("mrst_busy", 32'(busy_o), 32'd0);
        rxq.push_back(8'h2B);
        pulse_start();
        wait_idle("mrst");
        expq = '{8'h24, 8'h23, 8'h30, 8'h30};
        chk_frames("mrst", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
